lunc_encoder: RTL and testbench

- Transmit-side companion of the case-filter datapath: turns a stream of (byte, desired case mode) pairs into the escape-command byte stream that the filter consumes.
- Emits ESC plus a command letter whenever the requested mode differs from the mode last signalled, then forwards the data byte.
- Sits upstream of the filter on the same 8-bit byte interface. Uses valid/ready handshakes on both sides because inserted bytes create backpressure.

---
 rtl/lunc_encoder.sv | 160 ++++++++++++++++
 tb/tb_lunc_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lunc_encoder.sv
// lunc_encoder
//   Turns a stream of (data byte, requested case mode) pairs into the
//   escape-command byte stream consumed by the case filter. Whenever the
//   requested mode differs from the mode last signalled downstream, the
//   byte is preceded by ESC_CHAR and a command letter (N/L/U/C). Input
//   bytes equal to ESC_CHAR are dropped and flagged.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream pair valid
//   in_ready   encoder accepts the pair this cycle
//   in_data    data byte
//   in_mode    requested mode: 00=N, 01=L, 10=U, 11=C
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_data   encoded byte stream
//   cur_mode   mode last signalled downstream
//   drop_err   one-cycle pulse when an ESC_CHAR input byte was dropped
//   esc_count  saturating count of escape sequences started
module lunc_encoder #(
   parameter logic [7:0]  ESC_CHAR = 8'h1b,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [1:0]       cur_mode,
   output logic             drop_err,
   output logic [CNT_W-1:0] esc_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } state_t;

   state_t           state_q,     state_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_data_q,  out_data_d;
   logic [1:0]       cur_mode_q,  cur_mode_d;
   logic             drop_q,      drop_d;
   logic [CNT_W-1:0] esc_cnt_q,   esc_cnt_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic [1:0]       hold_mode_q, hold_mode_d;

   logic slot_free;
   logic accept;

   function automatic logic [7:0] cmd_letter(input logic [1:0] m);
      case (m)
         2'b00:   cmd_letter = 8'h4e; // N
         2'b01:   cmd_letter = 8'h4c; // L
         2'b10:   cmd_letter = 8'h55; // U
         default: cmd_letter = 8'h43; // C
      endcase
   endfunction

   // Output register can take a new byte when empty or being drained now.
   assign slot_free = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cur_mode_q  <= '0;
         drop_q      <= 1'b0;
         esc_cnt_q   <= '0;
         hold_data_q <= '0;
         hold_mode_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cur_mode_q  <= cur_mode_d;
         drop_q      <= drop_d;
         esc_cnt_q   <= esc_cnt_d;
         hold_data_q <= hold_data_d;
         hold_mode_q <= hold_mode_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      cur_mode_d  = cur_mode_q;
      drop_d      = 1'b0;
      esc_cnt_d   = esc_cnt_q;
      hold_data_d = hold_data_q;
      hold_mode_d = hold_mode_q;

      // A drained slot empties unless something below reloads it.
      if (slot_free) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_data == ESC_CHAR) begin
                  drop_d = 1'b1;
               end else if (in_mode == cur_mode_q) begin
                  out_data_d  = in_data;
                  out_valid_d = 1'b1;
               end else begin
                  out_data_d  = ESC_CHAR;
                  out_valid_d = 1'b1;
                  hold_data_d = in_data;
                  hold_mode_d = in_mode;
                  if (esc_cnt_q != '1) begin
                     esc_cnt_d = esc_cnt_q + CNT_W'(1);
                  end
                  state_d = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            if (slot_free) begin
               out_data_d  = cmd_letter(hold_mode_q);
               out_valid_d = 1'b1;
               cur_mode_d  = hold_mode_q;
               state_d     = ST_DATA;
            end
         end
         ST_DATA: begin
            if (slot_free) begin
               out_data_d  = hold_data_q;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == ST_IDLE) && slot_free;
      out_valid = out_valid_q;
      out_data  = out_data_q;
      cur_mode  = cur_mode_q;
      drop_err  = drop_q;
      esc_count = esc_cnt_q;
   end

endmodule

// File: tb/tb_lunc_encoder.sv
module tb_lunc_encoder;

   localparam logic [7:0] ESC = 8'h1b;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  cur_mode;
   logic        drop_err;
   logic [15:0] esc_count;

   // Second instance with a narrow counter for the saturation case.
   logic        in_valid2;
   logic        in_ready2;
   logic [7:0]  in_data2;
   logic [1:0]  in_mode2;
   logic        out_valid2;
   logic [7:0]  out_data2;
   logic [1:0]  cur_mode2;
   logic        drop_err2;
   logic [1:0]  esc_count2;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   lunc_encoder #(.ESC_CHAR(8'h1b), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .cur_mode(cur_mode),
      .drop_err(drop_err), .esc_count(esc_count)
   );

   lunc_encoder #(.ESC_CHAR(8'h1b), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data2), .in_mode(in_mode2),
      .out_valid(out_valid2), .out_ready(1'b1),
      .out_data(out_data2), .cur_mode(cur_mode2),
      .drop_err(drop_err2), .esc_count(esc_count2)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      int         n;
      logic [7:0] e0, e1, e2;
      logic [1:0] cm;
      int         esc;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every transfer on the output is popped and compared.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_byte: got=%0h expected=<none>", out_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_byte: got=%0h expected=%0h", out_data, e);
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [1:0] m);
      int n = 0;
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      @(negedge clock);
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("drop_err_pulse", 32'(drop_err), 32'(d == ESC));
      if (d == ESC) begin
         @(negedge clock);
         chk("drop_err_clear", 32'(drop_err), 32'd0);
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clock); #1;
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'h61, 2'd0, 1, 8'h61, 8'h00, 8'h00, 2'd0, 0};
      vecs[1] = '{8'h62, 2'd0, 1, 8'h62, 8'h00, 8'h00, 2'd0, 0};
      vecs[2] = '{8'h58, 2'd1, 3, 8'h1b, 8'h4c, 8'h58, 2'd1, 1};
      vecs[3] = '{8'h41, 2'd3, 3, 8'h1b, 8'h43, 8'h41, 2'd3, 2};
      vecs[4] = '{8'h42, 2'd3, 1, 8'h42, 8'h00, 8'h00, 2'd3, 2};
      vecs[5] = '{8'h1b, 2'd1, 0, 8'h00, 8'h00, 8'h00, 2'd3, 2};
      vecs[6] = '{8'h63, 2'd1, 3, 8'h1b, 8'h4c, 8'h63, 2'd1, 3};
      vecs[7] = '{8'h7a, 2'd2, 3, 8'h1b, 8'h55, 8'h7a, 2'd2, 4};
      vecs[8] = '{8'h30, 2'd0, 3, 8'h1b, 8'h4e, 8'h30, 2'd0, 5};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = '0;
      out_ready = 1'b1;
      in_valid2 = 1'b0;
      in_data2  = '0;
      in_mode2  = '0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_cur_mode",  32'(cur_mode),  32'd0);
      chk("rst_drop_err",  32'(drop_err),  32'd0);
      chk("rst_esc_count", 32'(esc_count), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Table-driven pairs with out_ready held high.
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].n > 0) exp_q.push_back(vecs[i].e0);
         if (vecs[i].n > 1) exp_q.push_back(vecs[i].e1);
         if (vecs[i].n > 2) exp_q.push_back(vecs[i].e2);
         send(vecs[i].data, vecs[i].mode);
         wait_empty();
         chk("vec_cur_mode",  32'(cur_mode),  32'(vecs[i].cm));
         chk("vec_esc_count", 32'(esc_count), 32'(vecs[i].esc));
      end

      // Mode-change timing: ESC, letter, data on consecutive cycles,
      // in_ready low for two cycles, cur_mode moves with the letter.
      exp_q.push_back(8'h1b);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h44);
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_data  = 8'h44;
      in_mode  = 2'd2;
      @(negedge clock);
      chk("seq_a_ready0", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("seq_a_esc",    32'(out_data), 32'h1b);
      chk("seq_a_ready1", 32'(in_ready), 32'd0);
      chk("seq_a_mode1",  32'(cur_mode), 32'd0);
      @(negedge clock);
      chk("seq_a_cmd",    32'(out_data), 32'h55);
      chk("seq_a_ready2", 32'(in_ready), 32'd0);
      chk("seq_a_mode2",  32'(cur_mode), 32'd2);
      @(negedge clock);
      chk("seq_a_data",   32'(out_data), 32'h44);
      chk("seq_a_ready3", 32'(in_ready), 32'd1);
      wait_empty();
      chk("seq_a_esc_count", 32'(esc_count), 32'd6);

      // Backpressure while the command letter sits in the output register.
      exp_q.push_back(8'h1b);
      exp_q.push_back(8'h4c);
      exp_q.push_back(8'h7a);
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_data  = 8'h7a;
      in_mode  = 2'd1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("seq_b_hold_data",  32'(out_data),  32'h4c);
         chk("seq_b_hold_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      wait_empty();
      chk("seq_b_cur_mode",  32'(cur_mode),  32'd1);
      chk("seq_b_esc_count", 32'(esc_count), 32'd7);

      // Reset in the DATA state discards the pending byte.
      exp_q.push_back(8'h1b);
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_data  = 8'h99;
      in_mode  = 2'd2;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
      @(negedge clock);
      chk("seq_c_letter", 32'(out_data), 32'h55);
      #1 reset = 1'b1;
      #1;
      chk("seq_c_rst_valid", 32'(out_valid), 32'd0);
      chk("seq_c_rst_data",  32'(out_data),  32'd0);
      chk("seq_c_rst_mode",  32'(cur_mode),  32'd0);
      chk("seq_c_rst_esc",   32'(esc_count), 32'd0);
      @(posedge clock); #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(negedge clock);
      chk("seq_c_no_output", 32'(out_valid), 32'd0);
      chk("seq_c_queue",     32'(exp_q.size()), 32'd0);

      // Narrow counter saturates at all-ones.
      for (int i = 0; i < 4; i++) begin
         int n = 0;
         @(posedge clock); #1;
         in_valid2 = 1'b1;
         in_data2  = 8'h20 + 8'(i);
         in_mode2  = 2'(i + 1);
         @(negedge clock);
         while (!in_ready2 && n < 50) begin
            @(negedge clock);
            n++;
         end
         if (!in_ready2) chk("sat_ready_timeout", 32'(in_ready2), 32'd1);
         @(posedge clock); #1;
         in_valid2 = 1'b0;
         repeat (4) @(posedge clock);
         @(negedge clock);
         if (i >= 2) chk("sat_esc_count", 32'(esc_count2), 32'd3);
         else        chk("sat_esc_count", 32'(esc_count2), 32'(i + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
